// File: rtl/norm_pkg.sv
// norm_pkg: shared widths and types for the norm/divide result output stage.
package norm_pkg;
   localparam int DATAWIDTH_DEFAULT = 16;
   localparam int DEPTH_DEFAULT = 8;
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction
   function automatic int occ_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
   typedef logic [DATAWIDTH_DEFAULT-1:0] result_t;
   typedef logic [occ_w(DEPTH_DEFAULT)-1:0] occ_t;
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: register array with one write port and an asynchronous read port.
module fifo_ram #(
   parameter int DATAWIDTH = 16,
   parameter int DEPTH = 8,
   parameter int AW = 3
) (
   input  logic                 clk,
   input  logic                 we_i,
   input  logic [AW-1:0]        waddr_i,
   input  logic [DATAWIDTH-1:0] wdata_i,
   input  logic [AW-1:0]        raddr_i,
   output logic [DATAWIDTH-1:0] rdata_o
);
   logic [DATAWIDTH-1:0] mem_q [DEPTH];
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end
   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/result_out_buffer.sv
// result_out_buffer: show-ahead FIFO absorbing datapath results, with drop accounting and almost_full credit.
// Optional RESULT_STATS_EN adds min/max/count statistics of accepted results.
module result_out_buffer import norm_pkg::*; #(
   parameter int DATAWIDTH = DATAWIDTH_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int RESERVE = 4,
   parameter int DROPW = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_valid,
   input  logic [DATAWIDTH-1:0]      i_data,
   output logic                      o_valid,
   output logic [DATAWIDTH-1:0]      o_data,
   input  logic                      i_ready,
   output logic                      almost_full,
   output logic [occ_w(DEPTH)-1:0]   count,
   output logic                      overflow,
   output logic [DROPW-1:0]          drop_count,
   input  logic                      i_clr_ovf
`ifdef RESULT_STATS_EN
   ,
   output logic [DATAWIDTH-1:0]      stat_min,
   output logic [DATAWIDTH-1:0]      stat_max,
   output logic [31:0]               stat_cnt
`endif
);
   localparam int AW = ptr_w(DEPTH);
   localparam int CW = occ_w(DEPTH);
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic af_q, af_d, ovf_q, ovf_d;
   logic [DROPW-1:0] drop_q, drop_d, drop_b;
   logic pop, push, drop, full;
   assign o_valid = (count_q != '0);
   assign full = (count_q == CW'(DEPTH));
   assign pop = o_valid & i_ready;
   assign push = i_valid & (~full | pop);
   assign drop = i_valid & full & ~pop;
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d = (push & ~pop) ? count_q + CW'(1) : (~push & pop) ? count_q - CW'(1) : count_q;
      af_d = (CW'(DEPTH) - count_d) <= CW'(RESERVE);
      // a drop in the clearing cycle is counted after the clear
      ovf_d = drop | (ovf_q & ~i_clr_ovf);
      drop_b = i_clr_ovf ? '0 : drop_q;
      drop_d = (drop & ~&drop_b) ? drop_b + DROPW'(1) : drop_b;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q <= '0;
         af_q <= 1'b0;
         ovf_q <= 1'b0;
         drop_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q <= count_d;
         af_q <= af_d;
         ovf_q <= ovf_d;
         drop_q <= drop_d;
      end
   end
   fifo_ram #(.DATAWIDTH(DATAWIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk(clk),
      .we_i(push),
      .waddr_i(wr_ptr_q),
      .wdata_i(i_data),
      .raddr_i(rd_ptr_q),
      .rdata_o(o_data)
   );
   assign almost_full = af_q;
   assign count = count_q;
   assign overflow = ovf_q;
   assign drop_count = drop_q;
`ifdef RESULT_STATS_EN
   logic [DATAWIDTH-1:0] min_q, min_d, min_b, max_q, max_d, max_b;
   logic [31:0] cnt_q, cnt_d, cnt_b;
   always_comb begin
      min_b = i_clr_ovf ? '1 : min_q;
      max_b = i_clr_ovf ? '0 : max_q;
      cnt_b = i_clr_ovf ? '0 : cnt_q;
      min_d = (push && i_data < min_b) ? i_data : min_b;
      max_d = (push && i_data > max_b) ? i_data : max_b;
      cnt_d = (push & ~&cnt_b) ? cnt_b + 32'd1 : cnt_b;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         min_q <= '1;
         max_q <= '0;
         cnt_q <= '0;
      end else begin
         min_q <= min_d;
         max_q <= max_d;
         cnt_q <= cnt_d;
      end
   end
   assign stat_min = min_q;
   assign stat_max = max_q;
   assign stat_cnt = cnt_q;
`endif
endmodule

// File: doc/result_out_buffer.md
Name: result_out_buffer

Overview:
- Output stage directly downstream of the norm/divide datapath (Dividend / sqrt(A²+B²+C²+D²)).
- Captures each 16-bit quotient on the datapath's o_valid strobe. The datapath has no backpressure, so every strobe must be absorbed or counted as dropped.
- Presents results to the consumer over a valid/ready handshake.
- Drives an almost_full credit signal that the issuing logic uses to throttle i_valid into the fixed-latency pipeline.

Parameters:
- DATAWIDTH, 16, result width (8.8 fixed-point quotient).
- DEPTH, 8, FIFO entries; must be a power of two and at least 2.
- RESERVE, 4, free-slot threshold for almost_full; set to at least the datapath latency in cycles; must be less than DEPTH.
- DROPW, 8, width of the saturating drop counter.

Ports:
- clk  in  1  clock; all flops on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- i_valid  in  1  datapath result strobe.
- i_data  in  DATAWIDTH  datapath quotient.
- o_valid  out  1  head entry available.
- o_data  out  DATAWIDTH  head entry.
- i_ready  in  1  consumer accepts the head entry.
- almost_full  out  1  free slots <= RESERVE.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; set when a result is dropped.
- drop_count  out  DROPW  number of dropped results, saturating.
- i_clr_ovf  in  1  synchronous clear of overflow and drop_count.

Behaviour:
- Reset (rst=0, asynchronous): pointers=0, count=0, o_valid=0, almost_full=0, overflow=0, drop_count=0. o_data is don't-care while o_valid=0.
- Storage and pointers:
  - Circular RAM, DEPTH entries.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is tracked in its own register, not derived from the pointers.
- Show-ahead output: o_data = mem[rd_ptr]; o_valid = (count != 0). Both come from registered state.
- Read: pop = o_valid & i_ready. rd_ptr advances on the next edge. o_data must hold stable while o_valid=1 and i_ready=0.
- Write: push = i_valid & (count != DEPTH | pop). When full, a simultaneous pop frees a slot and the write is accepted.
- Latency: a write at edge N gives o_valid=1 from cycle N+1. No same-cycle bypass when empty.
- Count update: +1 on push only; -1 on pop only; unchanged on both or neither.
- Drop: i_valid=1 while full and pop=0.
  - Data is discarded and pointers are unchanged.
  - overflow <= 1.
  - drop_count <= drop_count+1, saturating at 2^DROPW-1.
- Clear: i_clr_ovf=1 clears overflow and drop_count on that edge. A drop in the same cycle wins: overflow=1, drop_count=1.
- almost_full = (DEPTH - count) <= RESERVE, registered from the next-state count, so it is aligned with count.
- The block has no FSM states. The control state is {count==0: EMPTY, 0<count<DEPTH: PARTIAL, count==DEPTH: FULL}.
- Reset asserted mid-operation flushes all entries immediately. Consumer data in flight is lost; o_valid falls asynchronously.

Optional Feature:
- Macro: RESULT_STATS_EN.
- When defined:
  - Adds outputs stat_min and stat_max (DATAWIDTH each) and stat_cnt (32 bits).
  - These track the unsigned min, max and count of accepted (pushed) results.
  - Reset values: stat_min = all ones, stat_max = 0, stat_cnt = 0.
  - Cleared to the same values by i_clr_ovf.
  - stat_cnt saturates at its maximum value.
- When undefined: these ports and their logic are absent. Core behaviour is identical.

Decomposition:
- Package norm_pkg:
  - DATAWIDTH default.
  - Function clog2-based width helpers.
  - Typedef result_t = logic [DATAWIDTH-1:0].
  - Typedef occ_t for count.
- One sub-module, fifo_ram: a dual-pointer register array with one write port and an asynchronous read port, no reset on the data array.
- All control (count, drop, almost_full, stats) lives in result_out_buffer.

Test Plan:
- Reset then write 0x0180 with i_ready=0 → o_valid=1 on the next cycle, o_data=0x0180, count=1, almost_full=0.
- Push 8 results 0x0001..0x0008 with i_ready=0:
  - almost_full rises when count=4.
  - At count=8, push a 9th (0x0009) → dropped; overflow=1, drop_count=1.
  - Drain → 0x0001..0x0008 in order, no 0x0009.
- FIFO full, i_valid=1 with i_ready=1 in the same cycle → push accepted, count stays 8, overflow stays 0. Last read-out value equals the new data.
- Continuous i_valid with i_ready toggling 1010 for 40 cycles → pointers wrap. The output sequence equals the input sequence minus exactly drop_count entries. The count invariant holds every cycle.
- 300 drops while full, DROPW=8 → drop_count=255. Then i_clr_ovf with a drop in the same cycle → overflow=1, drop_count=1.
- Assert rst=0 asynchronously at count=5 → o_valid=0 and count=0 immediately. After release, a write of 0x00FF appears as the first output.
- With RESULT_STATS_EN: push 0x0300, 0x0040, 0x1000 → stat_min=0x0040, stat_max=0x1000, stat_cnt=3.
